// File: rtl/sequential_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master side issues start with operands; the slave side is the divider.
interface sequential_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Controller and datapath share one block; results are held until the next
// accepted start. Optional macro DIVIDER_DIV_ZERO_DETECT_EN short-circuits a
// zero divisor straight to DONE and raises div_by_zero with the result.
module sequential_divider #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sequential_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    counter_q, counter_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
    logic             dbz_q, dbz_d;
`endif

    // Next-state, shift/subtract step and result commit. The partial remainder
    // is always below the divisor between steps, so its (WIDTH+1)-bit top bit
    // is zero there and only the shifted/trial values carry the extra bit.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        divisor_d   = divisor_q;
        quo_d       = quo_q;
        partial_d   = partial_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
        dbz_d       = dbz_q;
`endif
        shifted     = {partial_q, quo_q[WIDTH-1]};
        trial       = shifted - {1'b0, divisor_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    divisor_d = bus.divisor;
                    quo_d     = bus.dividend;
                    partial_d = '0;
                    counter_d = '0;
                    busy_d    = 1'b1;
                    state_d   = CALC;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
                    dbz_d     = 1'b0;
                    if (bus.divisor == '0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    partial_d = trial[WIDTH-1:0];
                    quo_d     = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    partial_d = shifted[WIDTH-1:0];
                    quo_d     = {quo_q[WIDTH-2:0], 1'b0};
                end
                counter_d = counter_q + 1'b1;
                if (counter_q == CW'(WIDTH - 1)) begin
                    quotient_d  = quo_d;
                    remainder_d = partial_d;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            divisor_q   <= '0;
            quo_q       <= '0;
            partial_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            divisor_q   <= divisor_d;
            quo_q       <= quo_d;
            partial_q   <= partial_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
            dbz_q       <= dbz_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
- Multi-cycle unsigned restoring divider; the arithmetic inverse of the team's shift-add sequential multiplier, using the same shift-register style.
- Controller FSM and datapath are in one block.
- Accepts dividend/divisor on a start pulse and produces quotient/remainder WIDTH cycles later with a one-cycle done strobe.
- Sits beside the multiplier in the arithmetic unit and shares its start/busy/done handshake style.

Parameters:
- WIDTH, 4, operand width in bits; also the quotient and remainder width. Legal range is 2 or more.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned numerator; sampled with start.
- divisor  input  WIDTH  unsigned denominator; sampled with start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle strobe; quotient/remainder valid.
- quotient  output  WIDTH  result; held until next accepted start.
- remainder  output  WIDTH  result; held until next accepted start.
- div_by_zero  output  1  divisor was 0 for the current result; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, all internal registers 0.
  - Reset asserted mid-operation aborts it immediately; no done is produced.
  - After rst_n releases, the first start is accepted normally.
- States: IDLE, CALC, DONE.
- IDLE:
  - On the edge where start=1, latch divisor into divisor_reg (WIDTH bits).
  - Load the quotient/shift register with dividend.
  - Clear the partial-remainder register (WIDTH+1 bits).
  - Set counter=0 and go to CALC.
- CALC, once per cycle:
  - Shift {partial_rem, quo_shift} left by 1; the MSB of quo_shift enters partial_rem[0].
  - trial = shifted partial_rem − {1'b0, divisor_reg}, computed at WIDTH+1 bits.
  - If trial MSB is 0: partial_rem=trial and quo_shift[0]=1.
  - Otherwise restore: keep the shifted value and set quo_shift[0]=0.
  - counter increments.
  - On the iteration where counter==WIDTH−1, also copy the final values to quotient/remainder (low WIDTH bits of partial_rem) and go to DONE.
- DONE:
  - done=1 for exactly one cycle; next edge goes to IDLE.
- Latency:
  - Start accepted at edge k → done high in the cycle following edge k+WIDTH.
  - busy high from edge k to edge k+WIDTH+1.
  - A new start is accepted at edge k+WIDTH+2 at the earliest.
- Boundary conditions:
  - start while busy (CALC or DONE) is ignored; operands are not resampled.
  - Operand inputs may change freely after the accepting edge.
  - dividend < divisor → quotient=0, remainder=dividend.
  - divisor=1 → quotient=dividend, remainder=0.
  - Without the optional feature, divisor=0 runs the full WIDTH iterations and yields quotient=all ones, remainder=dividend, div_by_zero=0.
  - quotient/remainder never change except at result-commit or reset.

Optional Feature:
- Macro: DIVIDER_DIV_ZERO_DETECT_EN.
- Defined:
  - A start with divisor==0 skips CALC: IDLE → DONE on the accepting edge.
  - done appears the cycle after that edge (latency 1).
  - quotient=all ones, remainder=dividend, div_by_zero=1, registered with the result.
  - div_by_zero is cleared to 0 when the next start is accepted.
- Not defined:
  - div_by_zero is tied 0.
  - Zero divisor follows the normal WIDTH-cycle path (result as in Boundary conditions).
- The port exists in both builds.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start pulse at edge k → done high only in the cycle after edge k+4; quotient=4, remainder=1; busy high edges k..k+5.
- WIDTH=4: 15/1 → q=15, r=0; 7/9 → q=0, r=7; 0/5 → q=0, r=0. Each result is held stable across 10 idle cycles after done.
- WIDTH=4, 9/0:
  - Macro undefined → after 4 cycles q=15, r=9, div_by_zero=0.
  - Macro defined → done one cycle after start; q=15, r=9, div_by_zero=1.
  - A following 8/2 → q=4, r=0, div_by_zero=0.
- Start 13/3 with start held high for 3 cycles and operands changed to 6/2 mid-CALC → a single done, q=4, r=1. Start re-asserted in the DONE cycle is ignored.
- rst_n pulled low for half a cycle during CALC iteration 2 → busy, done, q and r all 0 immediately with no done pulse. A subsequent 10/4 → q=2, r=2.
- WIDTH=8: 255/16 → q=15, r=15 with done after 8 cycles; 200/200 → q=1, r=0. Random 1000-vector sweep checked against reference integer division.
